// File: rtl/pkt_ingress_pkg.sv
// pkt_ingress_pkg: state encodings and slot/word constants shared by the ingress stage and RAM controller
package pkt_ingress_pkg;
  localparam int DATA_W = 64;
  localparam int RAM_ARRAY = 8;
  localparam int SEQ_W = 3;
  localparam int LEN_W = 10;
  localparam int BYTES_PER_WORD = 8;
  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_PKT     = 4'b0010,
    S_DISCARD = 4'b0100,
    S_GAP     = 4'b1000
  } state_t;
endpackage

// File: rtl/pkt_ingress_seq_slot_tracker.sv
// pkt_ingress_seq_slot_tracker: slot occupancy vector, round-robin write pointer and claim/release arbitration
module pkt_ingress_seq_slot_tracker
  import pkt_ingress_pkg::*;
#(
  parameter int ram_array = RAM_ARRAY,
  parameter int seq_width = SEQ_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_claim,
  input  logic                 i_advance,
  input  logic                 i_free,
  input  logic [seq_width-1:0] i_free_seq,
  input  logic                 i_release,
  input  logic [seq_width-1:0] i_release_seq,
  output logic [ram_array-1:0] o_busy,
  output logic [seq_width-1:0] o_wr_ptr,
  output logic                 o_slot_free
);
  logic [ram_array-1:0] r_busy, w_set, w_clr;
  logic [seq_width-1:0] r_wr_ptr;
  always_comb begin
    w_set = '0;
    w_clr = '0;
    w_set[r_wr_ptr] = i_claim;
    if (i_release) w_clr[i_release_seq] = 1'b1;
    if (i_free) w_clr[i_free_seq] = 1'b1;
  end
  // set is applied after clear so a claim beats a same-cycle release of that slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      r_wr_ptr <= r_wr_ptr + seq_width'(i_advance);
    end
  end
  assign o_busy = r_busy;
  assign o_wr_ptr = r_wr_ptr;
  assign o_slot_free = !r_busy[r_wr_ptr];
endmodule

// File: rtl/pkt_ingress_seq.sv
// pkt_ingress_seq: assigns round-robin RAM slots to a sop/eop packet stream and drives the slot write stream
module pkt_ingress_seq
  import pkt_ingress_pkg::*;
#(
  parameter int data_width = DATA_W,
  parameter int ram_array  = RAM_ARRAY,
  parameter int seq_width  = SEQ_W,
  parameter int len_width  = LEN_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [data_width-1:0] s_data_in,
  input  logic                  s_valid_in,
  input  logic                  s_sop_in,
  input  logic                  s_eop_in,
  input  logic [2:0]            s_empty_in,
  output logic                  s_ready_out,
  output logic [data_width-1:0] data_out,
  output logic                  data_valid_out,
  output logic [seq_width-1:0]  pack_seq_out,
  output logic [len_width-1:0]  data_length_out,
  output logic [3:0]            last_bytes_out,
  output logic                  pkt_done_out,
  output logic                  pkt_abort_out,
  input  logic                  slot_release_in,
  input  logic [seq_width-1:0]  slot_release_seq_in,
  output logic [ram_array-1:0]  slot_busy_out
);
  localparam logic [len_width:0] CNT_ONE = {{len_width{1'b0}}, 1'b1};
  state_t r_state, w_next;
  logic [seq_width-1:0] r_seq, w_wr_ptr;
  logic [len_width:0] r_cnt, w_cnt_nxt;
  logic [data_width-1:0] r_data;
  logic [len_width-1:0] r_len;
  logic [3:0] r_last;
  logic r_valid, r_done, r_abort;
  logic w_slot_free, w_ready, w_claim, w_emit, w_done, w_abort;
  pkt_ingress_seq_slot_tracker #(.ram_array(ram_array), .seq_width(seq_width)) u_slots (
    .clk(clk),
    .reset_n(reset_n),
    .i_claim(w_claim),
    .i_advance(w_done),
    .i_free(w_abort),
    .i_free_seq(r_seq),
    .i_release(slot_release_in),
    .i_release_seq(slot_release_seq_in),
    .o_busy(slot_busy_out),
    .o_wr_ptr(w_wr_ptr),
    .o_slot_free(w_slot_free)
  );
  assign w_cnt_nxt = (r_state == S_IDLE) ? CNT_ONE : r_cnt + CNT_ONE;
  always_comb begin
    w_next = r_state;
    w_ready = 1'b0;
    w_claim = 1'b0;
    w_emit = 1'b0;
    w_done = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = w_slot_free;
        if (s_valid_in && w_slot_free && s_sop_in) begin
          w_claim = 1'b1;
          w_emit = 1'b1;
          w_done = s_eop_in;
          w_next = s_eop_in ? S_GAP : S_PKT;
        end
      end
      S_PKT: begin
        // a new sop is refused here and retried from IDLE after the abort
        w_ready = !(s_valid_in && s_sop_in);
        if (!s_valid_in || s_sop_in) begin
          w_abort = 1'b1;
          w_next = s_valid_in ? S_IDLE : S_DISCARD;
        end else if (r_cnt[len_width]) begin
          w_abort = 1'b1;
          w_next = s_eop_in ? S_GAP : S_DISCARD;
        end else begin
          w_emit = 1'b1;
          w_done = s_eop_in;
          w_next = s_eop_in ? S_GAP : S_PKT;
        end
      end
      S_DISCARD: begin
        w_ready = 1'b1;
        w_next = (s_valid_in && s_eop_in) ? S_IDLE : S_DISCARD;
      end
      S_GAP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seq <= '0;
      r_cnt <= '0;
      r_data <= '0;
      r_len <= '0;
      r_last <= '0;
      r_valid <= 1'b0;
      r_done <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_done <= w_done;
      r_abort <= w_abort;
      if (w_claim) r_seq <= w_wr_ptr;
      if (w_emit) r_cnt <= w_cnt_nxt;
      if (w_emit) r_data <= s_data_in;
      if (w_done) r_len <= w_cnt_nxt[len_width] ? {len_width{1'b1}} : w_cnt_nxt[len_width-1:0];
      if (w_done) r_last <= 4'(BYTES_PER_WORD) - {1'b0, s_empty_in};
    end
  end
  assign s_ready_out = reset_n & w_ready;
  assign data_out = r_data;
  assign data_valid_out = r_valid;
  assign pack_seq_out = r_seq;
  assign data_length_out = r_len;
  assign last_bytes_out = r_last;
  assign pkt_done_out = r_done;
  assign pkt_abort_out = r_abort;
endmodule

// File: tb/tb_pkt_ingress_seq.sv
// tb_pkt_ingress_seq: scoreboard bench for the packet ingress slot sequencer
module tb_pkt_ingress_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [63:0] s_data_in = '0;
  logic s_valid_in = 1'b0, s_sop_in = 1'b0, s_eop_in = 1'b0;
  logic [2:0] s_empty_in = '0;
  logic s_ready_out;
  logic [63:0] data_out;
  logic data_valid_out;
  logic [2:0] pack_seq_out;
  logic [9:0] data_length_out;
  logic [3:0] last_bytes_out;
  logic pkt_done_out, pkt_abort_out;
  logic slot_release_in = 1'b0;
  logic [2:0] slot_release_seq_in = '0;
  logic [7:0] slot_busy_out;
  typedef struct packed {logic [63:0] d; logic [2:0] s;} wexp_t;
  typedef struct packed {logic [9:0] len; logic [3:0] lb; logic [2:0] s;} dexp_t;
  wexp_t q_w[$];
  dexp_t q_d[$];
  logic [2:0] q_a[$];
  wexp_t ew;
  dexp_t ed;
  logic [2:0] ea;
  int n_cmp = 0, n_bad = 0;
  bit prev_done = 1'b0;
  pkt_ingress_seq dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_data_in(s_data_in),
    .s_valid_in(s_valid_in),
    .s_sop_in(s_sop_in),
    .s_eop_in(s_eop_in),
    .s_empty_in(s_empty_in),
    .s_ready_out(s_ready_out),
    .data_out(data_out),
    .data_valid_out(data_valid_out),
    .pack_seq_out(pack_seq_out),
    .data_length_out(data_length_out),
    .last_bytes_out(last_bytes_out),
    .pkt_done_out(pkt_done_out),
    .pkt_abort_out(pkt_abort_out),
    .slot_release_in(slot_release_in),
    .slot_release_seq_in(slot_release_seq_in),
    .slot_busy_out(slot_busy_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic sop, input logic eop, input logic [2:0] emp,
                     input logic [63:0] d, output bit acc, input logic rel = 1'b0, input logic [2:0] rs = 3'd0);
    @(negedge clk);
    s_valid_in = v;
    s_sop_in = sop;
    s_eop_in = eop;
    s_empty_in = emp;
    s_data_in = d;
    slot_release_in = rel;
    slot_release_seq_in = rs;
    #1 acc = v & s_ready_out;
  endtask
  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, acc);
  endtask
  task automatic word(input logic sop, input logic eop, input logic [2:0] emp, input bit emit,
                      input logic [2:0] s, input logic rel = 1'b0, input logic [2:0] rs = 3'd0);
    logic [63:0] d = {$urandom, $urandom};
    bit acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) cyc(1'b1, sop, eop, emp, d, acc, (i == 0) ? rel : 1'b0, rs);
    chk("accept", 64'(acc), 64'(1));
    if (acc && emit) q_w.push_back(wexp_t'{d, s});
  endtask
  task automatic pkt(input int n, input logic [2:0] emp, input logic [2:0] s);
    for (int i = 0; i < n; i++) word(i == 0, i == n - 1, emp, 1'b1, s);
    q_d.push_back(dexp_t'{(n >= 1024) ? 10'd1023 : 10'(n), 4'd8 - {1'b0, emp}, s});
  endtask
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_done) chk("gap_idle", 64'(data_valid_out), 64'(0));
      if (data_valid_out) begin
        if (q_w.size() == 0) chk("extra_word", 64'(data_valid_out), 64'(0));
        else begin
          ew = q_w.pop_front();
          chk("data", data_out, ew.d);
          chk("seq", 64'(pack_seq_out), 64'(ew.s));
        end
      end
      if (pkt_done_out) begin
        if (q_d.size() == 0) chk("extra_done", 64'(pkt_done_out), 64'(0));
        else begin
          ed = q_d.pop_front();
          chk("length", 64'(data_length_out), 64'(ed.len));
          chk("last_bytes", 64'(last_bytes_out), 64'(ed.lb));
          chk("done_seq", 64'(pack_seq_out), 64'(ed.s));
        end
      end
      if (pkt_abort_out) begin
        if (q_a.size() == 0) chk("extra_abort", 64'(pkt_abort_out), 64'(0));
        else begin
          ea = q_a.pop_front();
          chk("abort_seq", 64'(pack_seq_out), 64'(ea));
          chk("abort_valid", 64'(data_valid_out), 64'(0));
        end
      end
      prev_done = pkt_done_out;
    end else prev_done = 1'b0;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
  initial begin
    bit acc;
    logic [63:0] d0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(s_ready_out), 64'(0));
    chk("rst_valid", 64'(data_valid_out), 64'(0));
    chk("rst_data", data_out, 64'(0));
    chk("rst_seq", 64'(pack_seq_out), 64'(0));
    chk("rst_done", 64'(pkt_done_out), 64'(0));
    chk("rst_abort", 64'(pkt_abort_out), 64'(0));
    chk("rst_busy", 64'(slot_busy_out), 64'(0));
    @(negedge clk);
    #2 reset_n = 1'b1;
    pkt(4, 3'd0, 3'd0);
    pkt(1, 3'd7, 3'd1);
    pkt(10, 3'd3, 3'd2);
    idle(2);
    chk("busy_three", 64'(slot_busy_out), 64'h07);
    for (int k = 3; k < 8; k++) pkt(2, 3'(k), 3'(k));
    idle(2);
    chk("busy_full", 64'(slot_busy_out), 64'hff);
    d0 = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 3'd0, d0, acc);
      chk("stall_ready", 64'(s_ready_out), 64'(0));
    end
    cyc(1'b1, 1'b1, 1'b0, 3'd0, d0, acc, 1'b1, 3'd0);
    chk("release_cycle_accept", 64'(acc), 64'(0));
    cyc(1'b1, 1'b1, 1'b0, 3'd0, d0, acc);
    chk("post_release_accept", 64'(acc), 64'(1));
    q_w.push_back(wexp_t'{d0, 3'd0});
    word(1'b0, 1'b0, 3'd0, 1'b1, 3'd0);
    word(1'b0, 1'b1, 3'd2, 1'b1, 3'd0);
    q_d.push_back(dexp_t'{10'd3, 4'd6, 3'd0});
    for (int k = 1; k < 8; k++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, acc, 1'b1, 3'(k));
    idle(1);
    chk("busy_after_release", 64'(slot_busy_out), 64'h01);
    pkt(2, 3'd0, 3'd1);
    for (int i = 0; i < 3; i++) word(i == 0, 1'b0, 3'd0, 1'b1, 3'd2);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, acc);
    q_a.push_back(3'd2);
    word(1'b0, 1'b0, 3'd0, 1'b0, 3'd2);
    word(1'b0, 1'b1, 3'd0, 1'b0, 3'd2);
    idle(1);
    chk("busy_after_gap_abort", 64'(slot_busy_out), 64'h03);
    pkt(2, 3'd0, 3'd2);
    pkt(1024, 3'd0, 3'd3);
    for (int i = 0; i < 1025; i++) word(i == 0, i == 1024, 3'd0, i < 1024, 3'd4);
    q_a.push_back(3'd4);
    idle(2);
    chk("busy_after_oversize", 64'(slot_busy_out), 64'h0f);
    pkt(1, 3'd0, 3'd4);
    word(1'b1, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 3'd5);
    word(1'b0, 1'b1, 3'd0, 1'b1, 3'd5);
    q_d.push_back(dexp_t'{10'd2, 4'd8, 3'd5});
    idle(2);
    chk("busy_claim_beats_release", 64'(slot_busy_out), 64'h3f);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, acc, 1'b1, 3'd6);
    idle(1);
    chk("busy_idle_release", 64'(slot_busy_out), 64'h3f);
    for (int i = 0; i < 5; i++) word(i == 0, 1'b0, 3'd0, 1'b1, 3'd6);
    @(negedge clk);
    #2 reset_n = 1'b0;
    s_valid_in = 1'b0;
    #1;
    chk("midrst_valid", 64'(data_valid_out), 64'(0));
    chk("midrst_data", data_out, 64'(0));
    chk("midrst_seq", 64'(pack_seq_out), 64'(0));
    chk("midrst_busy", 64'(slot_busy_out), 64'(0));
    chk("midrst_ready", 64'(s_ready_out), 64'(0));
    chk("midrst_words_left", 64'(q_w.size()), 64'(0));
    @(negedge clk);
    #2 reset_n = 1'b1;
    pkt(2, 3'd1, 3'd0);
    idle(3);
    chk("words_left", 64'(q_w.size()), 64'(0));
    chk("dones_left", 64'(q_d.size()), 64'(0));
    chk("aborts_left", 64'(q_a.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
